// File: rtl/rptr_empty_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fifo_ptr_pkg
// Purpose  : Pointer helpers shared by the read- and write-side controllers
//            of the asynchronous FIFO. Provides the pointer-width calculation
//            and generic binary/Gray conversion functions.
// Revision : 1.0 - initial release
// ============================================================================
package fifo_ptr_pkg;

    // Widest pointer the generic conversion functions accept.
    localparam int PTR_W_MAX = 32;

    // A pointer carries one extra wrap bit beyond the RAM address.
    function automatic int ptr_width(input int addr_width);
        return addr_width + 1;
    endfunction

    function automatic logic [PTR_W_MAX-1:0] bin2gray(input logic [PTR_W_MAX-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Each binary bit is the XOR of all Gray bits at or above it.
    function automatic logic [PTR_W_MAX-1:0] gray2bin(input logic [PTR_W_MAX-1:0] g);
        logic [PTR_W_MAX-1:0] b;
        b[PTR_W_MAX-1] = g[PTR_W_MAX-1];
        for (int i = PTR_W_MAX - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rptr_empty_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : rptr_empty_ctrl_if
// Purpose  : Read-side control/status bundle between the FIFO read logic
//            (master) and the read-pointer controller (slave).
// Revision : 1.0 - initial release
// ============================================================================
interface rptr_empty_ctrl_if
    import fifo_ptr_pkg::*;
#(
    parameter int ADDR_WIDTH = 4
);
    localparam int PTR_W = ptr_width(ADDR_WIDTH);

    logic                  rinc;
    logic                  rflush;
    logic [PTR_W-1:0]      wptr_sync;
    logic [PTR_W-1:0]      ae_thresh;
    logic [PTR_W-1:0]      rptr;
    logic [ADDR_WIDTH-1:0] raddr;
    logic                  empty;
    logic                  almost_empty;
    logic [PTR_W-1:0]      rcount;
    logic                  underflow;

    modport master (
        output rinc, rflush, wptr_sync, ae_thresh,
        input  rptr, raddr, empty, almost_empty, rcount, underflow
    );

    modport slave (
        input  rinc, rflush, wptr_sync, ae_thresh,
        output rptr, raddr, empty, almost_empty, rcount, underflow
    );

endinterface
`default_nettype wire

// File: rtl/rptr_empty_ctrl_gray2bin.sv
`default_nettype none
// ============================================================================
// Module   : gray2bin
// Purpose  : Parametrised Gray-to-binary converter (XOR prefix from the MSB).
//            Purely combinational; shared by read and write controllers.
// Revision : 1.0 - initial release
// ============================================================================
module gray2bin #(
    parameter int WIDTH = 5
) (
    input  logic [WIDTH-1:0] gray_i,
    output logic [WIDTH-1:0] bin_o
);

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            assign bin_o[gi] = ^gray_i[WIDTH-1:gi];
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/rptr_empty_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : rptr_empty_ctrl
// Purpose  : Read-domain pointer and status controller of the async FIFO.
//            Keeps binary/Gray read pointers, registered empty, occupancy
//            count and almost-empty flag, and supports a flush that jumps the
//            read pointer to the synchronised write pointer.
//            Optional sticky underflow detection: RPTR_EMPTY_UNDERFLOW_EN.
// Revision : 1.0 - initial release
// ============================================================================
module rptr_empty_ctrl
    import fifo_ptr_pkg::*;
#(
    parameter int ADDR_WIDTH = 4
) (
    input  logic             rclk,
    input  logic             rst,
    rptr_empty_ctrl_if.slave rif
);

    localparam int PTR_W = ptr_width(ADDR_WIDTH);

    logic [PTR_W-1:0] w_wbin;
    logic             w_pop;
    logic [PTR_W-1:0] rbin_q,   rbin_d;
    logic [PTR_W-1:0] rptr_q,   rgray_d;
    logic [PTR_W-1:0] rcount_q, cnt_d;
    logic             empty_q,  empty_d;
    logic             ae_q,     ae_d;

    gray2bin #(
        .WIDTH (PTR_W)
    ) u_wptr_g2b (
        .gray_i (rif.wptr_sync),
        .bin_o  (w_wbin)
    );

    // Next pointer, count and flag values; flush overrides any pop.
    always_comb begin
        w_pop   = rif.rinc & ~empty_q;
        rbin_d  = rif.rflush ? w_wbin : (rbin_q + {{ADDR_WIDTH{1'b0}}, w_pop});
        rgray_d = rbin_d ^ (rbin_d >> 1);
        cnt_d   = w_wbin - rbin_d;
        empty_d = (rgray_d == rif.wptr_sync);
        ae_d    = (cnt_d <= rif.ae_thresh);
    end

    // Pointer and status registers; reset leaves the FIFO seen as empty.
    always_ff @(posedge rclk or posedge rst) begin
        if (rst) begin
            rbin_q   <= '0;
            rptr_q   <= '0;
            rcount_q <= '0;
            empty_q  <= 1'b1;
            ae_q     <= 1'b1;
        end else begin
            rbin_q   <= rbin_d;
            rptr_q   <= rgray_d;
            rcount_q <= cnt_d;
            empty_q  <= empty_d;
            ae_q     <= ae_d;
        end
    end

    assign rif.rptr         = rptr_q;
    assign rif.raddr        = rbin_q[ADDR_WIDTH-1:0];
    assign rif.empty        = empty_q;
    assign rif.almost_empty = ae_q;
    assign rif.rcount       = rcount_q;

`ifdef RPTR_EMPTY_UNDERFLOW_EN
    logic uf_q, uf_d;

    // Sticky pop-while-empty; a flush clears it even if it coincides with one.
    always_comb begin
        uf_d = rif.rflush ? 1'b0 : (uf_q | (rif.rinc & empty_q));
    end

    // Underflow flag register.
    always_ff @(posedge rclk or posedge rst) begin
        if (rst) begin
            uf_q <= 1'b0;
        end else begin
            uf_q <= uf_d;
        end
    end

    assign rif.underflow = uf_q;
`else
    assign rif.underflow = 1'b0;
`endif

endmodule
`default_nettype wire

// File: doc/rptr_empty_ctrl.md
Name: rptr_empty_ctrl

Overview:
Read-side pointer and status controller for the asynchronous FIFO, and the successor to the basic read-pointer/empty block. It keeps the binary and Gray read pointers and the registered empty flag, and adds a read-side occupancy count, a programmable almost-empty flag, a flush, and optional underflow detection. It sits in the read clock domain. It consumes the write pointer already synchronised into that domain and drives the RAM read address plus the Gray pointer sent to the write side.

Parameters:
ADDR_WIDTH, 4, RAM address bits; FIFO depth = 2^ADDR_WIDTH; pointers are ADDR_WIDTH+1 bits.

Ports:
rclk  in  1  read-domain clock; all state on rising edge
rst  in  1  asynchronous, active-high reset
rinc  in  1  pop request
rflush  in  1  discard all contents; read pointer jumps to write pointer
wptr_sync  in  ADDR_WIDTH+1  Gray write pointer, already synchronised to rclk
ae_thresh  in  ADDR_WIDTH+1  almost-empty threshold in words (quasi-static)
rptr  out  ADDR_WIDTH+1  registered Gray read pointer, to write-side synchroniser
raddr  out  ADDR_WIDTH  RAM read address = rbin[ADDR_WIDTH-1:0]
empty  out  1  registered empty flag
almost_empty  out  1  registered, count <= ae_thresh
rcount  out  ADDR_WIDTH+1  registered occupancy, 0..2^ADDR_WIDTH
underflow  out  1  sticky pop-while-empty flag (see Optional Feature)

Behaviour:
- Reset (rst=1, asynchronous, immediate): rbin=0, rptr=0, raddr=0, empty=1, almost_empty=1, rcount=0, underflow=0. Reset has priority over every input and may assert mid-operation.
- Combinational: wbin = gray2bin(wptr_sync).
- Pop qualifier: pop = rinc & ~empty; rinc while empty never moves the pointer.
- Next pointer, with rflush priority:
  - rflush=1: rbin_next = wbin
  - else: rbin_next = rbin + pop, modulo 2^(ADDR_WIDTH+1); natural wrap, MSB toggles each lap.
- rgray_next = rbin_next ^ (rbin_next >> 1). rptr is registered from rgray_next; no combinational path from inputs to rptr.
- cnt_next = (wbin - rbin_next) mod 2^(ADDR_WIDTH+1).
- Registered each cycle:
  - empty <= (rgray_next == wptr_sync)
  - rcount <= cnt_next
  - almost_empty <= (cnt_next <= ae_thresh)
- Latency:
  - A pop is reflected in raddr, rptr, rcount and flags on the next edge.
  - A wptr_sync change deasserts empty and updates rcount one edge later.
  - Flags are pessimistic: write-domain progress appears only after synchronisation.
- Simultaneous rinc and rflush: flush wins; the pop is ignored and does not count as underflow.
- Full FIFO: rcount = 2^ADDR_WIDTH (MSBs differ, lower bits equal); empty=0.
- ae_thresh=0: almost_empty equals empty. ae_thresh >= depth: almost_empty always 1.
- rcount is valid only while the write side obeys full. Overflow corruption is not detected here.

Optional Feature:
Macro RPTR_EMPTY_UNDERFLOW_EN.
- Defined:
  - underflow is set on the edge after any cycle with rinc=1 & empty=1 & rflush=0.
  - It stays set until rflush or rst.
  - A flush in the same cycle as a pop-while-empty clears it.
- Undefined: underflow is tied to 0 and no detection logic is built. The port remains present in both builds.

Decomposition:
- Package fifo_ptr_pkg: bin2gray and gray2bin functions, and a PTR_W = ADDR_WIDTH+1 helper constant scheme shared with the write-side controller.
- One natural sub-module: gray2bin, a parametrised XOR-prefix converter. It is instantiated here for wbin and reused by the write side.

Test Plan:
- Reset, then wptr_sync=5'b00111 (bin 5), ae_thresh=2, rinc=0 -> next edge: empty=0, rcount=5, almost_empty=0, rptr=0, raddr=0.
- From the previous state, rinc=1 for 5 cycles -> raddr steps 0,1,2,3,4; almost_empty=1 once rcount=2; after the 5th pop empty=1, rcount=0, rptr=5'b00111.
- Wrap: write reaches bin 16 (wptr_sync=5'b11000) and 16 pops are issued -> rptr=5'b11000, raddr=0, empty=1. Full case with wptr_sync=5'b11000 and rbin=0 -> rcount=16.
- Underflow (macro defined): empty=1, rinc=1 for 1 cycle -> rbin unchanged, underflow=1 and held. Then rflush=1 with wptr_sync=5'b01101 (bin 9) -> next edge: rptr=5'b01101, raddr=9, empty=1, rcount=0, underflow=0.
- Flush vs pop: rcount=4, rinc=1 and rflush=1 together -> rbin=wbin, rcount=0, no underflow. Macro undefined -> underflow stays 0 under all stimulus.
- Mid-operation reset: rcount=7 with pops in flight, rst pulsed between edges -> all outputs return to reset values immediately, before the next rclk edge.
